// File: rtl/btb_assoc_if.sv
// Fetch-side BTB bus: two lookup slots, the recovery training port and flush control.
// The master modport belongs to the fetch/recovery side; the slave modport belongs to the BTB.
interface btb_assoc_if;
  logic [63:0] if_NPC0;
  logic [63:0] if_NPC1;
  logic        if_hit0;
  logic        if_hit1;
  logic [63:0] if_pred_addr0;
  logic [63:0] if_pred_addr1;
  logic        recover_valid;
  logic        recover_taken;
  logic [63:0] recover_NPC;
  logic [63:0] recover_actual_addr;
  logic        flush_req;
  logic        flush_busy;

  modport master (
    output if_NPC0, if_NPC1, recover_valid, recover_taken, recover_NPC,
           recover_actual_addr, flush_req,
    input  if_hit0, if_hit1, if_pred_addr0, if_pred_addr1, flush_busy
  );

  modport slave (
    input  if_NPC0, if_NPC1, recover_valid, recover_taken, recover_NPC,
           recover_actual_addr, flush_req,
    output if_hit0, if_hit1, if_pred_addr0, if_pred_addr1, flush_busy
  );
endinterface

// File: rtl/btb_assoc.sv
// Tagged 2-way set-associative BTB: two combinational lookups, training writes visible next cycle.
// No backpressure; lookups miss and training is dropped while the NUM_SETS-cycle flush sweep runs.
module btb_assoc #(
  parameter int NUM_SETS     = 64,
  parameter int LOG_NUM_SETS = 6,
  parameter int TAG_BITS     = 10
) (
  input logic        clock,
  input logic        reset,
  btb_assoc_if.slave bus
);
  localparam int TAG_LO = LOG_NUM_SETS + 2;
  localparam int TAG_HI = TAG_BITS + LOG_NUM_SETS + 1;

  typedef logic [LOG_NUM_SETS-1:0] idx_t;
  typedef logic [TAG_BITS-1:0]     tag_t;
  typedef enum logic {IDLE, SWEEP} state_t;

  state_t              state;
  idx_t                sweep_cnt;
  logic                flush_busy_q;
  logic [NUM_SETS-1:0] valid0;
  logic [NUM_SETS-1:0] valid1;
  logic [NUM_SETS-1:0] lru;   // 1 = way1 is least recently used
  tag_t                tag0 [NUM_SETS];
  tag_t                tag1 [NUM_SETS];
  logic [63:0]         tgt0 [NUM_SETS];
  logic [63:0]         tgt1 [NUM_SETS];

  logic [63:0] npc    [2];
  idx_t        l_idx  [2];
  logic        l_m0   [2];
  logic        l_m1   [2];
  logic        l_hit  [2];
  logic [63:0] l_pred [2];

  assign npc[0] = bus.if_NPC0;
  assign npc[1] = bus.if_NPC1;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      l_idx[s]  = npc[s][TAG_LO-1:2];
      l_m0[s]   = valid0[l_idx[s]] && (tag0[l_idx[s]] == npc[s][TAG_HI:TAG_LO]);
      l_m1[s]   = valid1[l_idx[s]] && (tag1[l_idx[s]] == npc[s][TAG_HI:TAG_LO]);
      l_hit[s]  = !flush_busy_q && (l_m0[s] || l_m1[s]);
      l_pred[s] = l_hit[s] ? (l_m0[s] ? tgt0[l_idx[s]] : tgt1[l_idx[s]]) : npc[s] + 64'd4;
    end
  end

  assign bus.if_hit0       = l_hit[0];
  assign bus.if_hit1       = l_hit[1];
  assign bus.if_pred_addr0 = l_pred[0];
  assign bus.if_pred_addr1 = l_pred[1];
  assign bus.flush_busy    = flush_busy_q;

  idx_t r_idx;
  tag_t r_tag;
  logic r_m0, r_m1, r_hit, train, alloc_way, wr_way, wr_tgt;
  logic unused_ok;

  assign r_idx     = bus.recover_NPC[TAG_LO-1:2];
  assign r_tag     = bus.recover_NPC[TAG_HI:TAG_LO];
  assign r_m0      = valid0[r_idx] && (tag0[r_idx] == r_tag);
  assign r_m1      = valid1[r_idx] && (tag1[r_idx] == r_tag);
  assign r_hit     = r_m0 || r_m1;
  assign train     = bus.recover_valid && !flush_busy_q;
  // Fill an empty way before evicting; way0 is preferred when both are empty.
  assign alloc_way = !valid0[r_idx] ? 1'b0 : (!valid1[r_idx] ? 1'b1 : lru[r_idx]);
  assign wr_way    = r_hit ? r_m1 : alloc_way;
  assign wr_tgt    = train && bus.recover_taken;
  assign unused_ok = &{1'b0, bus.recover_NPC};

  // Later assignments to the same set win: slot0 touch, slot1 touch, then training.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid0       <= '0;
      valid1       <= '0;
      lru          <= '0;
      state        <= IDLE;
      sweep_cnt    <= '0;
      flush_busy_q <= 1'b0;
    end else if (state == SWEEP) begin
      valid0[sweep_cnt] <= 1'b0;
      valid1[sweep_cnt] <= 1'b0;
      lru[sweep_cnt]    <= 1'b0;
      sweep_cnt         <= sweep_cnt + 1'b1;
      if (sweep_cnt == idx_t'(NUM_SETS - 1)) begin
        state        <= IDLE;
        flush_busy_q <= 1'b0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (l_hit[s]) lru[l_idx[s]] <= l_m0[s];
      end
      if (train) begin
        if (bus.recover_taken) begin
          if (wr_way) valid1[r_idx] <= 1'b1;
          else        valid0[r_idx] <= 1'b1;
          lru[r_idx] <= ~wr_way;
        end else if (r_hit) begin
          if (r_m0) valid0[r_idx] <= 1'b0;
          else      valid1[r_idx] <= 1'b0;
          lru[r_idx] <= r_m1;
        end
      end
      if (bus.flush_req) begin
        state        <= SWEEP;
        sweep_cnt    <= '0;
        flush_busy_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_tgt) begin
      if (wr_way) begin
        tag1[r_idx] <= r_tag;
        tgt1[r_idx] <= bus.recover_actual_addr;
      end else begin
        tag0[r_idx] <= r_tag;
        tgt0[r_idx] <= bus.recover_actual_addr;
      end
    end
  end
endmodule
